// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared constants and sample conversion for the I2S transmitter
package i2s_pkg;

  localparam int I2S_SLOTS      = 32;
  localparam int I2S_WORD_BITS  = 16;
  localparam int SLOT_LEFT_MSB  = 1;
  localparam int SLOT_RIGHT_MSB = 17;

  // Offset-binary to two's complement is an MSB flip; the 9 bits are then left-aligned.
  function automatic logic [I2S_WORD_BITS-1:0] offset9_to_s16(input logic [8:0] s);
    return {~s[8], s[7:0], 7'b0};
  endfunction

endpackage

// File: rtl/i2s_clock_gen.sv
// rtl/i2s_clock_gen.sv - BCLK divider, slot counter and LRCLK generation
module i2s_clock_gen
  import i2s_pkg::*;
#(
  parameter int BCLK_HALF = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       bclk,
  output logic       lrclk,
  output logic       fall_stb,
  output logic [4:0] slot_next
);

  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       slot;
  logic             div_tc;

  assign div_tc    = (div_cnt == DIV_W'(BCLK_HALF - 1));
  // The falling edge is the cycle in which a high BCLK reaches terminal count.
  assign fall_stb  = div_tc && bclk;
  assign slot_next = slot + 5'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      slot    <= 5'(I2S_SLOTS - 1);
      lrclk   <= 1'b1;
    end else begin
      if (div_tc) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (fall_stb) begin
        slot  <= slot_next;
        lrclk <= slot_next[4];
      end
    end
  end

endmodule

// File: rtl/i2s_audio_transmitter.sv
// rtl/i2s_audio_transmitter.sv - mono Philips I2S transmitter for a 9-bit offset-binary sample
module i2s_audio_transmitter
  import i2s_pkg::*;
#(
  parameter int BCLK_HALF = 4,
  parameter int WORD_BITS = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [8:0] i_sample,
  input  logic       i_mute,
  output logic       o_bclk,
  output logic       o_lrclk,
  output logic       o_sdata,
  output logic       o_sample_stb
);

  logic                 fall_stb;
  logic [4:0]           slot_next;
  logic [WORD_BITS-1:0] word;
  logic [WORD_BITS-1:0] shift;
  logic                 load_slot;

  i2s_clock_gen #(
    .BCLK_HALF (BCLK_HALF)
  ) u_clock_gen (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .bclk      (o_bclk),
    .lrclk     (o_lrclk),
    .fall_stb  (fall_stb),
    .slot_next (slot_next)
  );

  assign load_slot = (slot_next == 5'(SLOT_LEFT_MSB)) || (slot_next == 5'(SLOT_RIGHT_MSB));

  // Slot 0 reloads word but still shifts out the previous right-channel LSB.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      word         <= '0;
      shift        <= '0;
      o_sdata      <= 1'b0;
      o_sample_stb <= 1'b0;
    end else begin
      o_sample_stb <= 1'b0;
      if (fall_stb) begin
        if (slot_next == 5'd0) begin
          word         <= i_mute ? '0 : WORD_BITS'(offset9_to_s16(i_sample));
          o_sample_stb <= 1'b1;
        end
        if (load_slot) begin
          shift   <= word << 1;
          o_sdata <= word[WORD_BITS-1];
        end else begin
          shift   <= shift << 1;
          o_sdata <= shift[WORD_BITS-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_audio_transmitter.sv
// tb/tb_i2s_audio_transmitter.sv - directed vector bench for i2s_audio_transmitter
module tb_i2s_audio_transmitter;

  localparam int HALF  = 2;
  localparam int FRAME = 64 * HALF;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [8:0] i_sample = 9'h0;
  logic       i_mute = 1'b0;
  logic       o_bclk, o_lrclk, o_sdata, o_sample_stb;

  i2s_audio_transmitter #(
    .BCLK_HALF (HALF),
    .WORD_BITS (16)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_sample     (i_sample),
    .i_mute       (i_mute),
    .o_bclk       (o_bclk),
    .o_lrclk      (o_lrclk),
    .o_sdata      (o_sdata),
    .o_sample_stb (o_sample_stb)
  );

  always #5 i_clk = ~i_clk;

  int cyc;
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  typedef struct {
    logic [8:0]  sample;
    logic        mute;
    logic [15:0] expected;
  } vec_t;

  vec_t vecs[8];
  logic rx[0:9][0:31];
  int   n_vec  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input int actual, input int required);
    n_vec++;
    if (actual != required) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, required);
    end
  endtask

  // Every wait goes through here so the per-cycle timing model is checked on each cycle.
  task automatic tick();
    int t;
    @(negedge i_clk);
    if (i_rst_n && mon_en) begin
      t = cyc - 4;
      check("bclk", int'(o_bclk), (cyc / HALF) % 2);
      check("lrclk", int'(o_lrclk), (cyc < 4) ? 1 : int'(((t / 4) % 32) >= 16));
      check("sample_stb", int'(o_sample_stb), int'(cyc >= 4 && (t % FRAME) == 0));
      if (cyc >= 6 && (t % 4) == 2 && (t / FRAME) < 10)
        rx[t / FRAME][(t / 4) % 32] = o_sdata;
    end
  endtask

  task automatic wait_cyc(input int target);
    int budget = 4000;
    while (cyc != target && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check("wait_timeout", cyc, target);
  endtask

  function automatic logic [15:0] left_word(input int f);
    logic [15:0] w;
    for (int s = 0; s < 16; s++) w[15 - s] = rx[f][1 + s];
    return w;
  endfunction

  function automatic logic [15:0] right_word(input int f);
    logic [15:0] w;
    for (int s = 0; s < 15; s++) w[15 - s] = rx[f][17 + s];
    w[0] = rx[f + 1][0];
    return w;
  endfunction

  initial begin
    vecs[0] = '{9'h1FF, 1'b0, 16'h7F80};
    vecs[1] = '{9'h000, 1'b0, 16'h8000};
    vecs[2] = '{9'h100, 1'b0, 16'h0000};
    vecs[3] = '{9'h0FF, 1'b0, 16'hFF80};
    vecs[4] = '{9'h1FF, 1'b1, 16'h0000};
    vecs[5] = '{9'h080, 1'b0, 16'hC000};
    vecs[6] = '{9'h17F, 1'b0, 16'h3F80};
    vecs[7] = '{9'h001, 1'b0, 16'h8080};

    repeat (3) @(negedge i_clk);
    #1;
    check("rst_bclk", int'(o_bclk), 0);
    check("rst_lrclk", int'(o_lrclk), 1);
    check("rst_sdata", int'(o_sdata), 0);
    check("rst_stb", int'(o_sample_stb), 0);

    @(negedge i_clk);
    i_rst_n = 1'b1;
    mon_en  = 1'b1;

    // Inputs are valid only around the latch; afterwards random values, including mute, must be ignored.
    for (int i = 0; i < 8; i++) begin
      wait_cyc(FRAME * i + 2);
      i_sample = vecs[i].sample;
      i_mute   = vecs[i].mute;
      wait_cyc(FRAME * i + 6);
      i_sample = 9'($urandom);
      i_mute   = 1'($urandom);
      wait_cyc(FRAME * i + 4 + 4 * 8 + 1);
      i_sample = 9'($urandom);
    end
    wait_cyc(FRAME * 8 + 2);
    i_sample = 9'h1FF;
    i_mute   = 1'b0;
    wait_cyc(FRAME * 8 + 10);

    for (int i = 0; i < 8; i++) begin
      check($sformatf("left_v%0d", i), int'(left_word(i)), int'(vecs[i].expected));
      check($sformatf("right_v%0d", i), int'(right_word(i)), int'(vecs[i].expected));
    end

    // Asynchronous reset mid-frame (slot 10), then timing must restart from scratch.
    wait_cyc(FRAME * 8 + 4 + 4 * 10 + 1);
    mon_en = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_bclk", int'(o_bclk), 0);
    check("mid_rst_lrclk", int'(o_lrclk), 1);
    check("mid_rst_sdata", int'(o_sdata), 0);
    check("mid_rst_stb", int'(o_sample_stb), 0);
    repeat (2) tick();
    i_sample = 9'h000;
    i_mute   = 1'b0;
    i_rst_n  = 1'b1;
    mon_en   = 1'b1;
    wait_cyc(2 * FRAME + 10);
    check("post_rst_left", int'(left_word(0)), 16'h8000);
    check("post_rst_right", int'(right_word(0)), 16'h8000);
    check("post_rst_left_f1", int'(left_word(1)), 16'h8000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
